// File: rtl/fabric_port_in.sv
// fabric_port_in: serialises packets of up to 4 flits onto a credit-flow-controlled NoC link
module fabric_port_in #(
  parameter int WIDTH_NOC        = 8,
  parameter int NUM_VC           = 2,
  parameter int DEPTH_PER_VC     = 8,
  parameter int VC_ADDRESS_WIDTH = $clog2(NUM_VC),
  parameter int WIDTH_PAY        = WIDTH_NOC - 3 - VC_ADDRESS_WIDTH
) (
  input  logic                        clk_noc,
  input  logic                        rst_n,
  input  logic [4*WIDTH_PAY-1:0]      rtl_data_in,
  input  logic [1:0]                  rtl_len_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] rtl_vc_in,
  input  logic                        rtl_valid_in,
  output logic                        rtl_ready_out,
  output logic [WIDTH_NOC-1:0]        noc_flit_out,
  input  logic [NUM_VC-1:0]           noc_credits_in,
  output logic                        credit_err
);
  localparam int CW = $clog2(DEPTH_PER_VC + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH_PER_VC);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [4*WIDTH_PAY-1:0] data_q;
  logic [1:0] len_q, idx;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q;
  logic [CW-1:0] cnt [NUM_VC];
  logic send;
  logic [NUM_VC-1:0] send_vc, ovf;
  logic [WIDTH_PAY-1:0] pay;
  assign send = state == SEND && cnt[vc_q] != '0;
  assign pay = WIDTH_PAY'(data_q >> (idx * WIDTH_PAY));
  // a send and a returned credit on the same VC cancel; a credit into a full counter is dropped
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign send_vc[v] = send && vc_q == VC_ADDRESS_WIDTH'(v);
    assign ovf[v] = noc_credits_in[v] && !send_vc[v] && cnt[v] == FULL;
    always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) cnt[v] <= FULL;
      else if (send_vc[v] != noc_credits_in[v] && !ovf[v]) cnt[v] <= send_vc[v] ? cnt[v] - ONE : cnt[v] + ONE;
    end
  end
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rtl_ready_out <= 1'b1;
      noc_flit_out <= '0;
      credit_err <= 1'b0;
      data_q <= '0;
      len_q <= '0;
      vc_q <= '0;
      idx <= '0;
    end else begin
      credit_err <= credit_err | (|ovf);
      noc_flit_out <= send ? {1'b1, idx == 2'd0, idx == len_q, vc_q, pay} : '0;
      if (state == IDLE) begin
        if (rtl_valid_in) begin
          state <= SEND;
          rtl_ready_out <= 1'b0;
          data_q <= rtl_data_in;
          len_q <= rtl_len_in;
          vc_q <= rtl_vc_in;
          idx <= '0;
        end
      end else if (send) begin
        idx <= idx + 2'd1;
        if (idx == len_q) begin
          state <= IDLE;
          rtl_ready_out <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fabric_port_in.sv
// tb_fabric_port_in: scoreboard bench with a credit/downstream-buffer reference model
module tb_fabric_port_in;
  localparam int W = 8, NV = 2, D = 8, VW = 1, PW = 4;
  logic clk_noc = 1'b0, rst_n = 1'b0;
  logic [4*PW-1:0] rtl_data_in = '0;
  logic [1:0] rtl_len_in = '0;
  logic [VW-1:0] rtl_vc_in = '0;
  logic rtl_valid_in = 1'b0;
  logic rtl_ready_out, credit_err;
  logic [W-1:0] noc_flit_out;
  logic [NV-1:0] auto_cr = '0, man_cr = '0, noc_credits_in;
  logic auto_en = 1'b0;
  int total = 0, bad = 0;
  int avail [NV];
  logic err_m = 1'b0;
  logic [W-1:0] expq [$];
  assign noc_credits_in = auto_cr | man_cr;

  fabric_port_in dut (
    .clk_noc(clk_noc), .rst_n(rst_n), .rtl_data_in(rtl_data_in), .rtl_len_in(rtl_len_in),
    .rtl_vc_in(rtl_vc_in), .rtl_valid_in(rtl_valid_in), .rtl_ready_out(rtl_ready_out),
    .noc_flit_out(noc_flit_out), .noc_credits_in(noc_credits_in), .credit_err(credit_err)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // expected flits of a packet, built straight from the flit field layout
  task automatic push_pkt(input logic [1:0] len, input logic [VW-1:0] vc, input logic [4*PW-1:0] d);
    for (int i = 0; i <= int'(len); i++)
      expq.push_back({1'b1, i == 0, i == int'(len), vc, d[i*PW +: PW]});
  endtask

  task automatic send_pkt(input logic [1:0] len, input logic [VW-1:0] vc, input logic [4*PW-1:0] d);
    logic acc;
    int n = 0;
    @(negedge clk_noc);
    rtl_len_in = len;
    rtl_vc_in = vc;
    rtl_data_in = d;
    rtl_valid_in = 1'b1;
    forever begin
      acc = rtl_ready_out;
      @(posedge clk_noc);
      if (acc) break;
      n++;
      if (n > 2000) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: packet not taken after %0d cycles", n);
        break;
      end
      @(negedge clk_noc);
    end
    if (acc) push_pkt(len, vc, d);
  endtask

  task automatic pulse(input logic [NV-1:0] m, input int n);
    @(negedge clk_noc);
    man_cr = m;
    repeat (n) @(negedge clk_noc);
    man_cr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_noc);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk_noc);
    #2 rst_n = 1'b1;
  endtask

  // credit view of the downstream buffer: a flit observed after edge e used credit held before e,
  // a credit sampled at edge e only counts from the following decision
  task automatic monitor();
    logic [NV-1:0] cr_e;
    logic [W-1:0] f, e;
    int vf;
    forever begin
      @(posedge clk_noc);
      cr_e = rst_n ? noc_credits_in : '0;
      @(negedge clk_noc);
      if (!rst_n) begin
        expq.delete();
        for (int v = 0; v < NV; v++) avail[v] = D;
        err_m = 1'b0;
      end else begin
        f = noc_flit_out;
        if (f[W-1]) begin
          vf = int'(f[W-4 -: VW]);
          chk("credit_avail", avail[vf] > 0, 1);
          if (avail[vf] > 0) avail[vf]--;
          if (expq.size() == 0) chk("unexpected_flit", f, 0);
          else begin
            e = expq.pop_front();
            chk("flit", f, e);
          end
        end else chk("idle_word", f, 0);
        for (int v = 0; v < NV; v++)
          if (cr_e[v]) begin
            if (avail[v] == D) err_m = 1'b1;
            else avail[v]++;
          end
        for (int v = 0; v < NV; v++) chk("cnt", dut.cnt[v], avail[v]);
        chk("credit_err", credit_err, err_m);
      end
    end
  endtask

  // downstream buffer draining each flit after a random delay, in arrival order per VC
  task automatic downstream();
    int rel [NV][$];
    int cyc = 0, t, vf;
    forever begin
      @(negedge clk_noc);
      cyc++;
      if (!rst_n || !auto_en) begin
        for (int v = 0; v < NV; v++) rel[v].delete();
        auto_cr = '0;
      end else begin
        if (noc_flit_out[W-1]) begin
          vf = int'(noc_flit_out[W-4 -: VW]);
          t = cyc + int'($urandom_range(1, 6));
          if (rel[vf].size() > 0 && rel[vf][$] > t) t = rel[vf][$];
          rel[vf].push_back(t);
        end
        for (int v = 0; v < NV; v++)
          if (rel[v].size() > 0 && rel[v][0] <= cyc) begin
            void'(rel[v].pop_front());
            auto_cr[v] = 1'b1;
          end else auto_cr[v] = 1'b0;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    fork
      monitor();
      downstream();
    join_none
    repeat (2) @(negedge clk_noc);
    chk("rst_flit", noc_flit_out, 0);
    chk("rst_ready", rtl_ready_out, 1);
    chk("rst_err", credit_err, 0);
    chk("rst_cnt0", dut.cnt[0], D);
    chk("rst_cnt1", dut.cnt[1], D);
    #2 rst_n = 1'b1;
    // 4-flit packet with full credit
    send_pkt(2'd3, 1'b0, 16'hA5C3);
    @(negedge clk_noc);
    rtl_valid_in = 1'b0;
    chk("t1_latency", noc_flit_out, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_noc);
      chk("t1_valid", noc_flit_out[W-1], 1);
      chk("t1_ready", rtl_ready_out, i == 3);
    end
    chk("t1_cnt0", dut.cnt[0], 4);
    pulse(2'b01, 4);
    // exhaust vc1 credit with single-flit packets
    for (int i = 0; i < 9; i++) send_pkt(2'd0, 1'b1, 16'($urandom));
    @(negedge clk_noc);
    rtl_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_flit", noc_flit_out, 0);
      chk("t2_stall_ready", rtl_ready_out, 0);
      @(negedge clk_noc);
    end
    man_cr = 2'b10;
    @(negedge clk_noc);
    man_cr = '0;
    chk("t2_credit_lat", noc_flit_out, 0);
    @(negedge clk_noc);
    chk("t2_released", noc_flit_out[W-1:W-3], 3'b111);
    chk("t2_ready", rtl_ready_out, 1);
    send_pkt(2'd0, 1'b1, 16'($urandom));
    @(negedge clk_noc);
    rtl_valid_in = 1'b0;
    @(negedge clk_noc);
    chk("t2_stall10", noc_flit_out, 0);
    pulse(2'b10, 9);
    repeat (2) @(negedge clk_noc);
    chk("t2_cnt1", dut.cnt[1], D);
    // credit return coinciding with a send
    send_pkt(2'd3, 1'b0, 16'($urandom));
    @(negedge clk_noc);
    rtl_valid_in = 1'b0;
    @(negedge clk_noc);
    man_cr = 2'b01;
    chk("t3_cnt_a", dut.cnt[0], 7);
    @(negedge clk_noc);
    man_cr = '0;
    chk("t3_cnt_same", dut.cnt[0], 7);
    repeat (3) @(negedge clk_noc);
    chk("t3_final", dut.cnt[0], 5);
    pulse(2'b01, 3);
    // overflow while idle and full
    @(negedge clk_noc);
    chk("t4_err_before", credit_err, 0);
    pulse(2'b10, 1);
    chk("t4_cnt_sat", dut.cnt[1], D);
    chk("t4_err_set", credit_err, 1);
    send_pkt(2'd1, 1'b1, 16'($urandom));
    @(negedge clk_noc);
    rtl_valid_in = 1'b0;
    repeat (4) @(negedge clk_noc);
    chk("t4_err_sticky", credit_err, 1);
    pulse(2'b10, 2);
    // reset in the middle of a packet
    send_pkt(2'd3, 1'b0, 16'($urandom));
    @(negedge clk_noc);
    rtl_valid_in = 1'b0;
    repeat (2) @(negedge clk_noc);
    chk("t5_second_flit", noc_flit_out[W-1], 1);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_flit", noc_flit_out, 0);
    chk("t5_async_ready", rtl_ready_out, 1);
    @(negedge clk_noc);
    #2 rst_n = 1'b1;
    @(negedge clk_noc);
    chk("t5_cnt0", dut.cnt[0], D);
    chk("t5_cnt1", dut.cnt[1], D);
    chk("t5_ready", rtl_ready_out, 1);
    chk("t5_err", credit_err, 0);
    send_pkt(2'd2, 1'b1, 16'($urandom));
    @(negedge clk_noc);
    rtl_valid_in = 1'b0;
    @(negedge clk_noc);
    chk("t5_head", noc_flit_out[W-1:W-2], 2'b11);
    // random soak against the downstream model
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 10000; i++)
      send_pkt(2'($urandom_range(0, 3)), VW'($urandom_range(0, NV - 1)), 16'($urandom));
    @(negedge clk_noc);
    rtl_valid_in = 1'b0;
    n = 0;
    while (expq.size() > 0 && n < 1000) begin
      @(negedge clk_noc);
      n++;
    end
    chk("soak_drained", expq.size(), 0);
    repeat (20) @(negedge clk_noc);
    chk("soak_err", credit_err, 0);
    chk("soak_cnt0", dut.cnt[0], D);
    chk("soak_cnt1", dut.cnt[1], D);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
